multi_operand_adder_double_buffered: RTL and testbench

- N-channel join-and-reduce adder; the next generation of the two-operand double-buffered adder.
- Each of n_inputs valid/ready streams passes through its own 2-entry double buffer.
- The join fires when every channel enabled by a runtime mask holds data and the output buffer can accept.
- Sum goes through an output double buffer; wrap or saturate mode; overflow flag travels with the data.

---
 rtl/multi_operand_adder_pkg.sv | 11 +
 rtl/double_buffer_arst.sv | 52 +++++
 rtl/multi_operand_adder_double_buffered.sv | 83 ++++++++
 tb/tb_multi_operand_adder_double_buffered.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_operand_adder_pkg.sv
// Shared constants and width helper for the multi-operand join-and-reduce adder.
package multi_operand_adder_pkg;

    localparam int max_inputs = 16;

    // Saturating mode clamps back to the operand width; otherwise keep every carry bit.
    function automatic int sum_width(input int width, input int n_inputs, input int saturate);
        return (saturate != 0) ? width : width + $clog2(n_inputs);
    endfunction

endpackage

// File: rtl/double_buffer_arst.sv
// Two-entry FIFO skid stage with valid/ready on both sides and asynchronous active-low reset.
module double_buffer_arst #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [width-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [width-1:0] down_data
);

    logic [width-1:0] slot [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Ready comes straight from the occupancy register, so it never depends on down_ready.
    assign up_ready   = (count != 2'd2);
    assign down_valid = (count != 2'd0);
    assign down_data  = slot[rd_ptr];
    assign push       = up_valid && up_ready;
    assign pop        = down_valid && down_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= up_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multi_operand_adder_double_buffered.sv
// N-channel join-and-reduce adder: per-channel double buffers, masked join, and a buffered
// sum output that carries its overflow flag alongside the data.
module multi_operand_adder_double_buffered
    import multi_operand_adder_pkg::*;
#(
    parameter int width    = 8,
    parameter int n_inputs = 4,
    parameter int saturate = 0,
    localparam int out_width = sum_width(width, n_inputs, saturate)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_inputs-1:0]       in_valid,
    output logic [n_inputs-1:0]       in_ready,
    input  logic [n_inputs*width-1:0] in_data,
    input  logic [n_inputs-1:0]       chan_mask,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [out_width-1:0]      out_data,
    output logic                      out_overflow
);

    localparam int full_width = width + $clog2(n_inputs);

    logic [n_inputs-1:0]   buf_valid;
    logic [n_inputs-1:0]   buf_pop;
    logic [width-1:0]      buf_data [n_inputs];
    logic                  out_up_ready;
    logic                  fire;
    logic                  overflow;
    logic [full_width-1:0] full_sum;
    logic [out_width-1:0]  result;
    logic [out_width:0]    out_buf_data;

    // Unmasked channels count as ready so an empty mask fires on output space alone.
    assign fire    = out_up_ready && (&(buf_valid | ~chan_mask));
    assign buf_pop = chan_mask & {n_inputs{fire}};

    for (genvar i = 0; i < n_inputs; i++) begin : g_chan
        double_buffer_arst #(.width(width)) u_in_buf (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (in_valid[i]),
            .up_ready   (in_ready[i]),
            .up_data    (in_data[i*width +: width]),
            .down_valid (buf_valid[i]),
            .down_ready (buf_pop[i]),
            .down_data  (buf_data[i])
        );
    end

    always_comb begin
        full_sum = '0;
        for (int i = 0; i < n_inputs; i++) begin
            if (chan_mask[i]) begin
                full_sum = full_sum + full_width'(buf_data[i]);
            end
        end
    end

    if (saturate != 0) begin : g_sat
        localparam logic [full_width-1:0] max_val = {{(full_width-width){1'b0}}, {width{1'b1}}};
        assign overflow = (full_sum > max_val);
        assign result   = overflow ? '1 : full_sum[width-1:0];
    end else begin : g_wrap
        assign overflow = 1'b0;
        assign result   = full_sum;
    end

    double_buffer_arst #(.width(out_width + 1)) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (fire),
        .up_ready   (out_up_ready),
        .up_data    ({overflow, result}),
        .down_valid (out_valid),
        .down_ready (out_ready),
        .down_data  (out_buf_data)
    );

    assign {out_overflow, out_data} = out_buf_data;

endmodule

// File: tb/tb_multi_operand_adder_double_buffered.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_multi_operand_adder_double_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  chan_mask;
    logic        out_ready;

    logic [3:0]  in_ready_w;
    logic        out_valid_w;
    logic [9:0]  out_data_w;
    logic        out_overflow_w;
    logic [3:0]  in_ready_s;
    logic        out_valid_s;
    logic [7:0]  out_data_s;
    logic        out_overflow_s;

    int checks = 0;
    int failures = 0;
    int idx;
    int oidx;
    int gaps;
    logic acc;

    always #5 clk = ~clk;

    multi_operand_adder_double_buffered #(.width(8), .n_inputs(4), .saturate(0)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready_w),
        .in_data      (in_data),
        .chan_mask    (chan_mask),
        .out_valid    (out_valid_w),
        .out_ready    (out_ready),
        .out_data     (out_data_w),
        .out_overflow (out_overflow_w)
    );

    multi_operand_adder_double_buffered #(.width(8), .n_inputs(4), .saturate(1)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready_s),
        .in_data      (in_data),
        .chan_mask    (chan_mask),
        .out_valid    (out_valid_s),
        .out_ready    (out_ready),
        .out_data     (out_data_s),
        .out_overflow (out_overflow_s)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3,
                                 input logic [3:0] mask, input logic ordy);
        in_valid  = valid;
        in_data   = {d3, d2, d1, d0};
        chan_mask = mask;
        out_ready = ordy;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF, 1'b0);
        tick;
        tick;
        checkOutput("reset_in_ready_w", 32'(in_ready_w), 32'hF);
        checkOutput("reset_in_ready_s", 32'(in_ready_s), 32'hF);
        checkOutput("reset_out_valid", 32'(out_valid_w), 32'd0);
        checkOutput("reset_out_data", 32'(out_data_w), 32'd0);
        checkOutput("reset_overflow_s", 32'(out_overflow_s), 32'd0);
        rst = 1'b1;

        // Single vector, two-cycle latency
        applyStimulus(4'hF, 8'd10, 8'd20, 8'd30, 8'd40, 4'hF, 1'b1);
        tick;
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
        checkOutput("t1_in_ready", 32'(in_ready_w), 32'hF);
        checkOutput("t1_not_yet", 32'(out_valid_w), 32'd0);
        tick;
        checkOutput("t1_valid", 32'(out_valid_w), 32'd1);
        checkOutput("t1_sum_w", 32'(out_data_w), 32'd100);
        checkOutput("t1_sum_s", 32'(out_data_s), 32'd100);
        checkOutput("t1_ovf_s", 32'(out_overflow_s), 32'd0);
        tick;
        checkOutput("t1_drained", 32'(out_valid_w), 32'd0);

        // Back-to-back: full-scale then just-below-saturation
        applyStimulus(4'hF, 8'd255, 8'd255, 8'd255, 8'd255, 4'hF, 1'b1);
        tick;
        applyStimulus(4'hF, 8'd100, 8'd100, 8'd50, 8'd4, 4'hF, 1'b1);
        tick;
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
        checkOutput("max_valid", 32'(out_valid_w), 32'd1);
        checkOutput("max_sum_w", 32'(out_data_w), 32'd1020);
        checkOutput("max_ovf_w", 32'(out_overflow_w), 32'd0);
        checkOutput("max_sum_s", 32'(out_data_s), 32'd255);
        checkOutput("max_ovf_s", 32'(out_overflow_s), 32'd1);
        tick;
        checkOutput("b2b_valid", 32'(out_valid_s), 32'd1);
        checkOutput("b2b_sum_w", 32'(out_data_w), 32'd254);
        checkOutput("b2b_sum_s", 32'(out_data_s), 32'd254);
        checkOutput("b2b_ovf_s", 32'(out_overflow_s), 32'd0);
        tick;
        checkOutput("b2b_drained", 32'(out_valid_w), 32'd0);

        // Masked join: channel 1 is held back until the mask selects it
        applyStimulus(4'b0111, 8'd5, 8'd77, 8'd6, 8'd0, 4'b0101, 1'b1);
        tick;
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0101, 1'b1);
        checkOutput("mask_not_yet", 32'(out_valid_w), 32'd0);
        tick;
        checkOutput("mask_valid", 32'(out_valid_w), 32'd1);
        checkOutput("mask_sum", 32'(out_data_w), 32'd11);
        checkOutput("mask_in_ready", 32'(in_ready_w), 32'hF);
        tick;
        checkOutput("mask_no_refire", 32'(out_valid_w), 32'd0);
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'b0010, 1'b1);
        tick;
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
        checkOutput("retain_valid", 32'(out_valid_w), 32'd1);
        checkOutput("retain_sum", 32'(out_data_w), 32'd77);
        tick;
        checkOutput("retain_drained", 32'(out_valid_w), 32'd0);

        // Empty mask for exactly one cycle yields exactly one zero sum
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'h0, 1'b1);
        tick;
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
        checkOutput("zero_mask_valid", 32'(out_valid_w), 32'd1);
        checkOutput("zero_mask_sum_w", 32'(out_data_w), 32'd0);
        checkOutput("zero_mask_sum_s", 32'(out_data_s), 32'd0);
        tick;
        checkOutput("zero_mask_once", 32'(out_valid_w), 32'd0);

        // Backpressure: 8 vectors (sum 10+4k), out_ready low for the first 5 cycles
        idx  = 0;
        oidx = 0;
        gaps = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (idx < 8)
                applyStimulus(4'hF, 8'(idx + 1), 8'(idx + 2), 8'(idx + 3), 8'(idx + 4), 4'hF, cyc >= 5);
            else
                applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF, cyc >= 5);
            if (cyc == 3 || cyc == 4) begin
                checkOutput("bp_hold_valid", 32'(out_valid_w), 32'd1);
                checkOutput("bp_hold_data", 32'(out_data_w), 32'd10);
            end
            if (cyc == 4) begin
                checkOutput("bp_accepted", 32'(idx), 32'd4);
                checkOutput("bp_in_ready", 32'(in_ready_w), 32'h0);
            end
            if (out_ready && out_valid_w) begin
                checkOutput("bp_order", 32'(out_data_w), 32'(10 + 4 * oidx));
                oidx++;
            end else if (out_ready && oidx > 0 && oidx < 8) begin
                gaps++;
            end
            acc = (idx < 8) && (&in_ready_w);
            tick;
            if (acc) idx++;
        end
        checkOutput("bp_all_in", 32'(idx), 32'd8);
        checkOutput("bp_all_out", 32'(oidx), 32'd8);
        checkOutput("bp_gaps", 32'(gaps), 32'd0);

        // Skew: channel 3 arrives three cycles after the rest
        applyStimulus(4'b0111, 8'd1, 8'd2, 8'd3, 8'd0, 4'hF, 1'b1);
        tick;
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
        checkOutput("skew_wait1", 32'(out_valid_w), 32'd0);
        tick;
        checkOutput("skew_wait2", 32'(out_valid_w), 32'd0);
        tick;
        applyStimulus(4'b1000, 8'd0, 8'd0, 8'd0, 8'd9, 4'hF, 1'b1);
        checkOutput("skew_wait3", 32'(out_valid_w), 32'd0);
        tick;
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
        checkOutput("skew_wait4", 32'(out_valid_w), 32'd0);
        tick;
        checkOutput("skew_valid", 32'(out_valid_w), 32'd1);
        checkOutput("skew_sum", 32'(out_data_w), 32'd15);
        tick;
        checkOutput("skew_no_dup", 32'(out_valid_w), 32'd0);

        // Asynchronous reset while buffers are full
        applyStimulus(4'hF, 8'd1, 8'd1, 8'd1, 8'd1, 4'hF, 1'b0);
        for (int k = 0; k < 5; k++) tick;
        checkOutput("pre_rst_valid", 32'(out_valid_w), 32'd1);
        checkOutput("pre_rst_in_ready", 32'(in_ready_w), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_valid_w", 32'(out_valid_w), 32'd0);
        checkOutput("arst_valid_s", 32'(out_valid_s), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready_w), 32'hF);
        checkOutput("arst_data", 32'(out_data_w), 32'd0);
        tick;
        applyStimulus(4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
        rst = 1'b1;
        tick;
        checkOutput("post_rst_valid", 32'(out_valid_w), 32'd0);
        checkOutput("post_rst_in_ready", 32'(in_ready_s), 32'hF);
        tick;
        checkOutput("post_rst_empty", 32'(out_valid_w), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
